// File: rtl/shift_seq.sv
// shift_seq: multi-cycle shift sequencer wrapped around the 8-bit selectable
// shifter (4x74153 shift stage). A working register feeds the shifter. The
// sequencer captures the shifter output once per clock until the requested
// number of single-bit steps is done. This gives an N-bit shift, rotate or
// arithmetic shift, N = 0..7, under a START/BUSY/DONE handshake.
//
// Ports:
//   CLK              rising-edge clock
//   RST_bar          asynchronous active-low reset
//   START            request pulse, sampled only in IDLE
//   DIR              0 = left (shifter op 2'b10), 1 = right (shifter op 2'b11)
//   INTERP[1:0]      fill select: 00 zero, 01 one, 10 VALUE_IN[0], 11 VALUE_IN[7]
//   COUNT[2:0]       number of single-bit steps, 0..7
//   LOAD_VALUE[7:0]  operand, latched on an accepted START
//   SHIFT_OP_SEL     to shifter OP_SEL (2'b01 = pass-through)
//   SHIFT_INTERP_SEL to shifter INTERP_SEL
//   SHIFT_VALUE      working register, to shifter VALUE_IN
//   SHIFT_RESULT     from shifter VALUE_OUT (combinational)
//   RESULT           equals the working register
//   BUSY             high in SHIFT and DONE
//   DONE             one-cycle completion strobe
//   CARRY            (only with SHIFT_SEQ_CARRY_EN) last bit shifted out
//
// Build option: define SHIFT_SEQ_CARRY_EN to add the CARRY output and its logic.
//
// DELAY_RISE / DELAY_FALL are kept so this block can be parameterised like the
// TTL models. In this synthesizable view the registered outputs have no delay.

module shift_seq #(
    parameter int DELAY_RISE = 0,
    parameter int DELAY_FALL = 0
) (
    input  logic       CLK,
    input  logic       RST_bar,
    input  logic       START,
    input  logic       DIR,
    input  logic [1:0] INTERP,
    input  logic [2:0] COUNT,
    input  logic [7:0] LOAD_VALUE,
    output logic [1:0] SHIFT_OP_SEL,
    output logic [1:0] SHIFT_INTERP_SEL,
    output logic [7:0] SHIFT_VALUE,
    input  logic [7:0] SHIFT_RESULT,
    output logic [7:0] RESULT,
    output logic       BUSY,
    output logic       DONE
`ifdef SHIFT_SEQ_CARRY_EN
    ,
    output logic       CARRY
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] work_reg;
    logic [2:0] step_cnt;
    logic       dir_q;
    logic [1:0] interp_q;

    // Negative delays have no meaning for the propagation-delay parameters.
    if (DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_bad_delay
        $error("shift_seq: DELAY_RISE and DELAY_FALL must be non-negative");
    end

    // State register.
    always_ff @(posedge CLK or negedge RST_bar) begin
        if (!RST_bar) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake/shifter-control outputs.
    // The shifter is held in pass-through except while actually stepping.
    // As a result, SHIFT_RESULT mirrors the register in IDLE and DONE.
    always_comb begin
        state_next   = state;
        SHIFT_OP_SEL = 2'b01;
        BUSY         = 1'b0;
        DONE         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (START) begin
                    state_next = (COUNT == 3'd0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                SHIFT_OP_SEL = {1'b1, dir_q};
                BUSY         = 1'b1;
                // A counter of 1 means this edge performs the final capture.
                if (step_cnt <= 3'd1) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                BUSY       = 1'b1;
                DONE       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Working register, step counter and latched operation parameters.
    // Parameters change only on an accepted START.
    // This keeps SHIFT_INTERP_SEL static outside a running operation.
    // The counter only decrements while non-zero, so it can never wrap.
    always_ff @(posedge CLK or negedge RST_bar) begin
        if (!RST_bar) begin
            work_reg <= 8'h00;
            step_cnt <= 3'd0;
            dir_q    <= 1'b0;
            interp_q <= 2'b00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        work_reg <= LOAD_VALUE;
                        step_cnt <= COUNT;
                        dir_q    <= DIR;
                        interp_q <= INTERP;
                    end
                end
                ST_SHIFT: begin
                    work_reg <= SHIFT_RESULT;
                    if (step_cnt != 3'd0) begin
                        step_cnt <= step_cnt - 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SHIFT_SEQ_CARRY_EN
    // Carry records the bit leaving the register on each step.
    // It then holds until the next accepted START.
    always_ff @(posedge CLK or negedge RST_bar) begin
        if (!RST_bar) begin
            CARRY <= 1'b0;
        end else if (state == ST_IDLE && START) begin
            CARRY <= 1'b0;
        end else if (state == ST_SHIFT) begin
            CARRY <= dir_q ? work_reg[0] : work_reg[7];
        end
    end
`endif

    assign SHIFT_INTERP_SEL = interp_q;
    assign SHIFT_VALUE      = work_reg;
    assign RESULT           = work_reg;

endmodule
